// File: rtl/mul_arb_if.sv
// mul_arb_if: bundles the requester-side and multiplier-side signals of mul_arb.
// slave  = arbiter view, master = environment view (requesters + multiplier).
interface mul_arb_if #(
   parameter int XLEN = 32,
   parameter int N    = 4
);
   logic [N-1:0]      rq_valid_i;
   logic [N*XLEN-1:0] rq_a_i;
   logic [N*XLEN-1:0] rq_b_i;
   logic [N-1:0]      rq_ready_o;
   logic [N-1:0]      rsp_valid_o;
   logic [XLEN-1:0]   rsp_data_o;
   logic              rsp_err_o;
   logic [XLEN-1:0]   mul_a_o;
   logic [XLEN-1:0]   mul_b_o;
   logic              mul_req_o;
   logic              mul_ready_i;
   logic [XLEN-1:0]   mul_result_i;

   modport slave (
      input  rq_valid_i, rq_a_i, rq_b_i, mul_ready_i, mul_result_i,
      output rq_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
             mul_a_o, mul_b_o, mul_req_o
   );

   modport master (
      output rq_valid_i, rq_a_i, rq_b_i, mul_ready_i, mul_result_i,
      input  rq_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
             mul_a_o, mul_b_o, mul_req_o
   );
endinterface

// File: rtl/mul_arb.sv
// mul_arb: round-robin arbiter/sequencer sharing one multi-cycle multiplier
// among N requesters. One operand pair is latched per grant, the multiplier
// request is held until its ready pulse, and the low product word is returned
// to the winner as a one-cycle one-hot response.
// Optional feature macro: MUL_ARB_TIMEOUT_EN (aborts a BUSY phase after
// TIMEOUT cycles without mul_ready_i, answering with data 0 and err 1).
module mul_arb #(
   parameter int XLEN    = 32,
   parameter int N       = 4,
   parameter int TIMEOUT = 64
) (
   input  logic      clk_i,
   input  logic      rst_i,
   mul_arb_if.slave  bus
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [IW-1:0]   r_ptr;
   logic [IW-1:0]   r_id;
   logic            r_mul_req;
   logic [XLEN-1:0] r_mul_a;
   logic [XLEN-1:0] r_mul_b;
   logic [N-1:0]    r_rsp_valid;
   logic [XLEN-1:0] r_rsp_data;

   logic            w_found;
   logic [IW-1:0]   w_gnt_idx;
   logic [N-1:0]    w_rq_ready;
   logic            w_load;
   logic            w_done;
   logic            w_abort;
   logic            w_expire;

   // First set request at or above ptr, wrapping; returns {found, index}.
   // Scanning downward and overwriting leaves the nearest hit from ptr.
   function automatic logic [IW:0] rr_pick(input logic [N-1:0] valid,
                                           input logic [IW-1:0] ptr);
      logic [IW:0] res;
      int          idx;
      res = '0;
      for (int i = N - 1; i >= 0; i--) begin
         idx = (int'(ptr) + i) % N;
         if (valid[idx]) begin
            res = {1'b1, IW'(idx)};
         end
      end
      return res;
   endfunction

   assign {w_found, w_gnt_idx} = rr_pick(bus.rq_valid_i, r_ptr);

   // State register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state: IDLE lasts exactly one cycle per grant, BUSY ends on ready or timeout
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_found) begin
               w_state_nxt = ST_BUSY;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (bus.mul_ready_i || w_expire) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_BUSY;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Outputs/strobes: accept pulse in IDLE, completion/abort strobes in BUSY
   always_comb begin
      w_rq_ready = '0;
      w_load     = 1'b0;
      w_done     = 1'b0;
      w_abort    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_found) begin
               w_rq_ready[w_gnt_idx] = 1'b1;
               w_load                = 1'b1;
            end else begin
               w_load = 1'b0;
            end
         end
         ST_BUSY: begin
            // A ready arriving together with expiry is a normal completion.
            if (bus.mul_ready_i) begin
               w_done = 1'b1;
            end else if (w_expire) begin
               w_abort = 1'b1;
            end else begin
               w_done = 1'b0;
            end
         end
         default: begin
            w_load = 1'b0;
         end
      endcase
   end

   // Datapath: latch operands at grant, return product (or abort) to the owner
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_ptr       <= '0;
         r_id        <= '0;
         r_mul_req   <= 1'b0;
         r_mul_a     <= '0;
         r_mul_b     <= '0;
         r_rsp_valid <= '0;
         r_rsp_data  <= '0;
      end else begin
         r_rsp_valid <= '0;
         if (w_load) begin
            r_mul_a   <= bus.rq_a_i[int'(w_gnt_idx)*XLEN +: XLEN];
            r_mul_b   <= bus.rq_b_i[int'(w_gnt_idx)*XLEN +: XLEN];
            r_id      <= w_gnt_idx;
            r_ptr     <= IW'((int'(w_gnt_idx) + 1) % N);
            r_mul_req <= 1'b1;
         end else if (w_done) begin
            r_rsp_data        <= bus.mul_result_i;
            r_rsp_valid[r_id] <= 1'b1;
            r_mul_req         <= 1'b0;
         end else if (w_abort) begin
            r_rsp_data        <= '0;
            r_rsp_valid[r_id] <= 1'b1;
            r_mul_req         <= 1'b0;
         end else begin
            r_mul_req <= r_mul_req;
         end
      end
   end

`ifdef MUL_ARB_TIMEOUT_EN
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [TW-1:0] r_tcnt;
   logic          r_rsp_err;

   // BUSY-cycle counter, cleared on every grant
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_tcnt <= '0;
      end else if (w_load) begin
         r_tcnt <= '0;
      end else if (r_state == ST_BUSY) begin
         r_tcnt <= r_tcnt + TW'(1);
      end else begin
         r_tcnt <= r_tcnt;
      end
   end

   // Expiry on the TIMEOUT-th BUSY cycle
   assign w_expire = (r_state == ST_BUSY) && (r_tcnt == TW'(TIMEOUT - 1));

   // Error flag travels with the response; holds between responses
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_rsp_err <= 1'b0;
      end else if (w_done) begin
         r_rsp_err <= 1'b0;
      end else if (w_abort) begin
         r_rsp_err <= 1'b1;
      end else begin
         r_rsp_err <= r_rsp_err;
      end
   end

   assign bus.rsp_err_o = r_rsp_err;
`else
   // Without the timeout, BUSY waits for the multiplier indefinitely.
   assign w_expire      = 1'b0;
   assign bus.rsp_err_o = 1'b0;
`endif

   assign bus.rq_ready_o  = w_rq_ready;
   assign bus.rsp_valid_o = r_rsp_valid;
   assign bus.rsp_data_o  = r_rsp_data;
   assign bus.mul_a_o     = r_mul_a;
   assign bus.mul_b_o     = r_mul_b;
   assign bus.mul_req_o   = r_mul_req;

endmodule

// File: tb/tb_mul_arb.sv
// tb_mul_arb: randomized bench for mul_arb with a behavioural multiplier stub
// and a transaction-level reference model (pending set, rr pointer, product).
module tb_mul_arb;
   localparam int XLEN = 32;
   localparam int N    = 4;
`ifdef MUL_ARB_TIMEOUT_EN
   localparam int TMO  = 8;
`else
   localparam int TMO  = 64;
`endif

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   always #5 clk_i = ~clk_i;

   mul_arb_if #(.XLEN(XLEN), .N(N)) bus ();

   mul_arb #(.XLEN(XLEN), .N(N), .TIMEOUT(TMO)) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus)
   );

   // requester / multiplier stimulus
   logic [N-1:0]      tb_valid = '0;
   logic [N-1:0]      hold     = '0;
   logic [N*XLEN-1:0] tb_a     = '0;
   logic [N*XLEN-1:0] tb_b     = '0;
   logic              tb_mready = 1'b0;
   logic [XLEN-1:0]   tb_mres   = '0;
   int                stub_cnt  = 0;
   bit                stub_done = 1'b0;
   bit                stub_stuck = 1'b0;
   bit                idle_noise = 1'b0;

   assign bus.rq_valid_i   = tb_valid;
   assign bus.rq_a_i       = tb_a;
   assign bus.rq_b_i       = tb_b;
   assign bus.mul_ready_i  = tb_mready;
   assign bus.mul_result_i = tb_mres;

   // reference model
   bit              m_busy = 1'b0;
   int              m_ptr = 0, m_id = 0, m_bcnt = 0, m_last_grant = -1;
   logic [XLEN-1:0] m_a = '0, m_b = '0, m_data = '0;
   logic [N-1:0]    m_rsp_valid = '0;
   logic            m_err = 1'b0;

   // observed DUT activity
   int              g_q[$];
   int              r_id_q[$];
   logic [XLEN-1:0] r_data_q[$];
   logic            r_err_q[$];

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int pick(input logic [N-1:0] v, input int ptr);
      for (int i = 0; i < N; i++) begin
         if (v[(ptr + i) % N]) return (ptr + i) % N;
      end
      return -1;
   endfunction

   function automatic int onehot_idx(input logic [N-1:0] v);
      for (int i = 0; i < N; i++) if (v[i]) return i;
      return -1;
   endfunction

   function automatic int g_at(input int i);
      return (i < g_q.size()) ? g_q[i] : -1;
   endfunction
   function automatic int rid_at(input int i);
      return (i < r_id_q.size()) ? r_id_q[i] : -1;
   endfunction
   function automatic logic [XLEN-1:0] rdata_at(input int i);
      return (i < r_data_q.size()) ? r_data_q[i] : 32'hDEAD_BEEF;
   endfunction
   function automatic logic rerr_at(input int i);
      return (i < r_err_q.size()) ? r_err_q[i] : 1'bx;
   endfunction

   task automatic clear_q();
      g_q.delete(); r_id_q.delete(); r_data_q.delete(); r_err_q.delete();
   endtask

   task automatic set_ops(input int k, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
      tb_a[k*XLEN +: XLEN] = a;
      tb_b[k*XLEN +: XLEN] = b;
   endtask

   // multiplier stub: random latency, product of the operands it is given
   task automatic stub_drive();
      if (bus.mul_req_o && !stub_done && !stub_stuck) begin
         if (stub_cnt == 0) begin
            tb_mready = 1'b1;
            tb_mres   = bus.mul_a_o * bus.mul_b_o;
            stub_done = 1'b1;
         end else begin
            stub_cnt--;
            tb_mready = 1'b0;
         end
      end else begin
         tb_mready = (idle_noise && !bus.mul_req_o) ? 1'($urandom_range(0, 1)) : 1'b0;
         tb_mres   = $urandom;
         if (!bus.mul_req_o) begin
            stub_done = 1'b0;
            stub_cnt  = $urandom_range(0, 5);
         end
      end
   endtask

   // one clock: check outputs at negedge, step model, drive after posedge
   task automatic tick();
      int k;
      @(negedge clk_i);
      k = pick(tb_valid, m_ptr);
      chk("mul_req", 64'(bus.mul_req_o), 64'(m_busy));
      chk("rq_ready", 64'(bus.rq_ready_o), (!m_busy && k >= 0) ? 64'(1) << k : 64'(0));
      chk("rsp_valid", 64'(bus.rsp_valid_o), 64'(m_rsp_valid));
      chk("rsp_data", 64'(bus.rsp_data_o), 64'(m_data));
      chk("rsp_err", 64'(bus.rsp_err_o), 64'(m_err));
      if (m_busy) begin
         chk("mul_a", 64'(bus.mul_a_o), 64'(m_a));
         chk("mul_b", 64'(bus.mul_b_o), 64'(m_b));
      end
      if (|bus.rq_ready_o) g_q.push_back(onehot_idx(bus.rq_ready_o));
      if (|bus.rsp_valid_o) begin
         r_id_q.push_back(onehot_idx(bus.rsp_valid_o));
         r_data_q.push_back(bus.rsp_data_o);
         r_err_q.push_back(bus.rsp_err_o);
      end
      m_rsp_valid  = '0;
      m_last_grant = -1;
      if (!m_busy) begin
         if (k >= 0) begin
            m_a = tb_a[k*XLEN +: XLEN];
            m_b = tb_b[k*XLEN +: XLEN];
            m_id = k;
            m_ptr = (k + 1) % N;
            m_busy = 1'b1;
            m_bcnt = 0;
            m_last_grant = k;
         end
      end else begin
         m_bcnt++;
         if (tb_mready) begin
            m_busy = 1'b0;
            m_rsp_valid[m_id] = 1'b1;
            m_data = m_a * m_b;
            m_err = 1'b0;
         end
`ifdef MUL_ARB_TIMEOUT_EN
         else if (m_bcnt == TMO) begin
            m_busy = 1'b0;
            m_rsp_valid[m_id] = 1'b1;
            m_data = '0;
            m_err = 1'b1;
         end
`endif
      end
      @(posedge clk_i);
      #1;
      if (m_last_grant >= 0 && !hold[m_last_grant]) tb_valid[m_last_grant] = 1'b0;
      stub_drive();
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      tb_valid = '0; hold = '0; tb_mready = 1'b0;
      stub_done = 1'b0; stub_cnt = 0;
      m_busy = 1'b0; m_ptr = 0; m_data = '0; m_err = 1'b0; m_rsp_valid = '0;
      repeat (2) @(posedge clk_i);
      #1;
      chk("rst_mul_req", 64'(bus.mul_req_o), 64'(0));
      chk("rst_mul_a", 64'(bus.mul_a_o), 64'(0));
      chk("rst_mul_b", 64'(bus.mul_b_o), 64'(0));
      chk("rst_rsp_valid", 64'(bus.rsp_valid_o), 64'(0));
      chk("rst_rsp_data", 64'(bus.rsp_data_o), 64'(0));
      chk("rst_rsp_err", 64'(bus.rsp_err_o), 64'(0));
      rst_i = 1'b0;
      clear_q();
   endtask

   task automatic wait_resps(input int n, input int budget, input string tag);
      int c;
      c = 0;
      while (r_id_q.size() < n && c < budget) begin
         tick();
         c++;
      end
      chk(tag, 64'(r_id_q.size()), 64'(n));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int found;
      // single request 7*6
      do_reset();
      set_ops(0, 32'd7, 32'd6);
      tb_valid[0] = 1'b1;
      wait_resps(1, 40, "t1_done");
      tick();
      chk("t1_grant", 64'(g_at(0)), 64'(0));
      chk("t1_ready_cycles", 64'(g_q.size()), 64'(1));
      chk("t1_id", 64'(rid_at(0)), 64'(0));
      chk("t1_data", 64'(rdata_at(0)), 64'd42);
      chk("t1_err", 64'(rerr_at(0)), 64'(0));

      // all four at once from reset: grant order 0..3
      do_reset();
      for (int k = 0; k < N; k++) set_ops(k, 32'(k + 1), 32'd10);
      tb_valid = '1;
      wait_resps(4, 200, "t2_done");
      for (int k = 0; k < N; k++) begin
         chk("t2_grant", 64'(g_at(k)), 64'(k));
         chk("t2_id", 64'(rid_at(k)), 64'(k));
         chk("t2_data", 64'(rdata_at(k)), 64'(10 * (k + 1)));
      end

      // fairness: 1 and 3 held continuously, then 0 joins
      do_reset();
      hold[1] = 1'b1; hold[3] = 1'b1;
      set_ops(1, $urandom, $urandom);
      set_ops(3, $urandom, $urandom);
      tb_valid[1] = 1'b1; tb_valid[3] = 1'b1;
      wait_resps(4, 200, "t3_done");
      chk("t3_g0", 64'(g_at(0)), 64'(1));
      chk("t3_g1", 64'(g_at(1)), 64'(3));
      chk("t3_g2", 64'(g_at(2)), 64'(1));
      chk("t3_g3", 64'(g_at(3)), 64'(3));
      clear_q();
      set_ops(0, 32'd5, 32'd5);
      tb_valid[0] = 1'b1;
      wait_resps(3, 200, "t3_more");
      found = 0;
      for (int i = 0; i < 3; i++) if (g_at(i) == 0) found = 1;
      chk("t3_no_starve", 64'(found), 64'(1));

      // zero and all-ones operands on requester 2
      do_reset();
      set_ops(2, 32'd0, 32'hFFFF_FFFF);
      tb_valid[2] = 1'b1;
      wait_resps(1, 40, "t4a_done");
      chk("t4a_id", 64'(rid_at(0)), 64'(2));
      chk("t4a_data", 64'(rdata_at(0)), 64'(0));
      tick();
      clear_q();
      set_ops(2, 32'hFFFF_FFFF, 32'd2);
      tb_valid[2] = 1'b1;
      wait_resps(1, 40, "t4b_done");
      chk("t4b_data", 64'(rdata_at(0)), 64'hFFFF_FFFE);

      // asynchronous reset in the middle of BUSY
      tick();
      clear_q();
      stub_stuck = 1'b1;
      set_ops(0, 32'd3, 32'd5);
      tb_valid[0] = 1'b1;
      repeat (4) tick();
      #2;
      rst_i = 1'b1;
      #1;
      chk("t5_async_req", 64'(bus.mul_req_o), 64'(0));
      chk("t5_async_rsp", 64'(bus.rsp_valid_o), 64'(0));
      chk("t5_no_rsp", 64'(r_id_q.size()), 64'(0));
      do_reset();
      stub_stuck = 1'b0;
      idle_noise = 1'b1;
      repeat (10) tick();
      chk("t5_idle_noise", 64'(r_id_q.size()), 64'(0));
      set_ops(0, 32'd9, 32'd9);
      tb_valid[0] = 1'b1;
      wait_resps(1, 40, "t5_done");
      chk("t5_data", 64'(rdata_at(0)), 64'd81);
      idle_noise = 1'b0;

      // multiplier never answers
      do_reset();
      stub_stuck = 1'b1;
      set_ops(1, 32'd11, 32'd12);
      tb_valid[1] = 1'b1;
      repeat (30) tick();
`ifdef MUL_ARB_TIMEOUT_EN
      chk("t6_tmo_count", 64'(r_id_q.size()), 64'(1));
      chk("t6_tmo_id", 64'(rid_at(0)), 64'(1));
      chk("t6_tmo_err", 64'(rerr_at(0)), 64'(1));
      chk("t6_tmo_data", 64'(rdata_at(0)), 64'(0));
      chk("t6_tmo_req", 64'(bus.mul_req_o), 64'(0));
`else
      chk("t6_no_rsp", 64'(r_id_q.size()), 64'(0));
      chk("t6_still_busy", 64'(bus.mul_req_o), 64'(1));
      chk("t6_err_zero", 64'(bus.rsp_err_o), 64'(0));
`endif
      stub_stuck = 1'b0;

      // randomized traffic
      do_reset();
      idle_noise = 1'b1;
      for (int c = 0; c < 600; c++) begin
         tick();
         for (int k = 0; k < N; k++) begin
            if (!tb_valid[k]) begin
               if ($urandom_range(0, 3) == 0) tb_valid[k] = 1'b1;
            end else if ($urandom_range(0, 15) == 0) begin
               tb_valid[k] = 1'b0;
            end
            set_ops(k, ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom),
                       32'($urandom));
         end
      end
      tb_valid = '0;
      repeat (20) tick();
      chk("t7_activity", 64'(r_id_q.size() > 40), 64'(1));
      chk("t7_drained", 64'(bus.mul_req_o), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
